// File: rtl/os_systolic_array_if.sv
// Job control, operand stream and result drain of the output-stationary GEMM engine.
interface os_systolic_array_if #(
    parameter int ROWS      = 4,
    parameter int COLS      = 4,
    parameter int WORD_SIZE = 16,
    parameter int ACC_SIZE  = 40,
    parameter int K_W       = 8
);
    localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;

    logic                      start;
    logic [K_W-1:0]            k_len;
    logic                      busy;
    logic                      in_valid;
    logic                      in_ready;
    logic [ROWS*WORD_SIZE-1:0] left_in_bus;
    logic [COLS*WORD_SIZE-1:0] top_in_bus;
    logic                      out_valid;
    logic                      out_ready;
    logic [COLS*ACC_SIZE-1:0]  out_bus;
    logic [ROW_W-1:0]          out_row;
    logic                      out_last;
    logic                      done;

    modport master (
        output start, k_len, in_valid, left_in_bus, top_in_bus, out_ready,
        input  busy, in_ready, out_valid, out_bus, out_row, out_last, done
    );

    modport slave (
        input  start, k_len, in_valid, left_in_bus, top_in_bus, out_ready,
        output busy, in_ready, out_valid, out_bus, out_row, out_last, done
    );
endinterface

// File: rtl/os_systolic_array.sv
// Output-stationary systolic GEMM engine: C = A*B, A is ROWS x K, B is K x COLS.
// Operands arrive unskewed, one k-beat per handshake; each PE keeps its own
// C element and the result leaves row by row over a valid/ready drain port.
//
// state | meaning
// IDLE  | waiting for start; start clears the grid and latches k_len
// LOAD  | accepting k_len operand beats, bubbles when in_valid is low
// FLUSH | ROWS+COLS cycles letting the last skewed beat reach PE(ROWS-1,COLS-1)
// DRAIN | presenting one C row per handshake, done after the last row
module os_systolic_array #(
    parameter int ROWS      = 4,
    parameter int COLS      = 4,
    parameter int WORD_SIZE = 16,
    parameter int ACC_SIZE  = 40,
    parameter int K_W       = 8
) (
    input  logic               clk,
    input  logic               rst,
    os_systolic_array_if.slave io
);
    localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int FL_W  = $clog2(ROWS + COLS);
    localparam int BUS_W = COLS * ACC_SIZE;

    typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DRAIN} state_t;

    state_t           state;
    logic [K_W-1:0]   beats_left;
    logic [FL_W-1:0]  flush_cnt;
    logic             busy_q;
    logic             in_ready_q;
    logic             out_valid_q;
    logic [ROW_W-1:0] out_row_q;
    logic             out_last_q;
    logic [BUS_W-1:0] out_bus_q;
    logic             done_q;

    logic             start_job;
    logic             clear;
    logic             beat;
    logic [ROW_W-1:0] next_row;
    logic [BUS_W-1:0] sel_bus;

    // Operand pipes carry {valid, data}; index [r][c] is the input seen by PE(r,c).
    logic [ROWS-1:0][COLS-1:0][WORD_SIZE:0] a_pipe;
    logic [ROWS-1:0][COLS-1:0][WORD_SIZE:0] b_pipe;
    logic [ROWS-1:0][BUS_W-1:0]             row_flat;

    assign start_job = (state == IDLE) && io.start;
    assign clear     = rst || start_job;
    assign beat      = io.in_valid && in_ready_q;

    assign io.busy      = busy_q;
    assign io.in_ready  = in_ready_q;
    assign io.out_valid = out_valid_q;
    assign io.out_row   = out_row_q;
    assign io.out_last  = out_last_q;
    assign io.out_bus   = out_bus_q;
    assign io.done      = done_q;

    // Select the row to load into out_bus: row 0 when leaving FLUSH, else the next row.
    always_comb begin
        next_row = (state == DRAIN) ? out_row_q + ROW_W'(1) : '0;
        sel_bus  = '0;
        for (int r = 0; r < ROWS; r++) begin
            if (next_row == ROW_W'(r)) sel_bus = row_flat[r];
        end
    end

    // Job sequencer with all handshake/status outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            beats_left  <= '0;
            flush_cnt   <= '0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_row_q   <= '0;
            out_last_q  <= 1'b0;
            out_bus_q   <= '0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (io.start) begin
                        busy_q     <= 1'b1;
                        beats_left <= io.k_len;
                        if (io.k_len == '0) begin
                            state     <= FLUSH;
                            flush_cnt <= FL_W'(ROWS + COLS - 1);
                        end else begin
                            state      <= LOAD;
                            in_ready_q <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    if (beat) begin
                        beats_left <= beats_left - K_W'(1);
                        if (beats_left == K_W'(1)) begin
                            state      <= FLUSH;
                            in_ready_q <= 1'b0;
                            flush_cnt  <= FL_W'(ROWS + COLS - 1);
                        end
                    end
                end
                FLUSH: begin
                    if (flush_cnt == '0) begin
                        state       <= DRAIN;
                        out_valid_q <= 1'b1;
                        out_row_q   <= '0;
                        out_last_q  <= (ROWS == 1);
                        out_bus_q   <= sel_bus;
                    end else begin
                        flush_cnt <= flush_cnt - FL_W'(1);
                    end
                end
                DRAIN: begin
                    if (io.out_ready) begin
                        if (out_last_q) begin
                            state       <= IDLE;
                            busy_q      <= 1'b0;
                            out_valid_q <= 1'b0;
                            out_row_q   <= '0;
                            out_last_q  <= 1'b0;
                            out_bus_q   <= '0;
                            done_q      <= 1'b1;
                        end else begin
                            out_row_q  <= next_row;
                            out_last_q <= (next_row == ROW_W'(ROWS - 1));
                            out_bus_q  <= sel_bus;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // A skew: row r reaches column 0 r cycles after its beat was accepted.
    for (genvar r = 0; r < ROWS; r++) begin : g_a_skew
        if (r == 0) begin : g_direct
            assign a_pipe[0][0] = {beat, io.left_in_bus[WORD_SIZE-1:0]};
        end else begin : g_delay
            logic [WORD_SIZE:0] sk [r];
            // r-stage delay line for row r.
            always_ff @(posedge clk) begin
                if (clear) begin
                    for (int d = 0; d < r; d++) sk[d] <= '0;
                end else begin
                    sk[0] <= {beat, io.left_in_bus[(r+1)*WORD_SIZE-1 -: WORD_SIZE]};
                    for (int d = 1; d < r; d++) sk[d] <= sk[d-1];
                end
            end
            assign a_pipe[r][0] = sk[r-1];
        end
    end

    // B skew: column c reaches row 0 c cycles after its beat was accepted.
    for (genvar c = 0; c < COLS; c++) begin : g_b_skew
        if (c == 0) begin : g_direct
            assign b_pipe[0][0] = {beat, io.top_in_bus[WORD_SIZE-1:0]};
        end else begin : g_delay
            logic [WORD_SIZE:0] sk [c];
            // c-stage delay line for column c.
            always_ff @(posedge clk) begin
                if (clear) begin
                    for (int d = 0; d < c; d++) sk[d] <= '0;
                end else begin
                    sk[0] <= {beat, io.top_in_bus[(c+1)*WORD_SIZE-1 -: WORD_SIZE]};
                    for (int d = 1; d < c; d++) sk[d] <= sk[d-1];
                end
            end
            assign b_pipe[0][c] = sk[c-1];
        end
    end

    // PE grid: a moves right, b moves down, each PE accumulates its own C element.
    for (genvar r = 0; r < ROWS; r++) begin : g_row
        for (genvar c = 0; c < COLS; c++) begin : g_col
            logic signed [WORD_SIZE-1:0]   a_q;
            logic signed [WORD_SIZE-1:0]   b_q;
            logic                          a_v;
            logic                          b_v;
            logic signed [ACC_SIZE-1:0]    acc;
            logic signed [2*WORD_SIZE-1:0] prod;

            assign prod = a_q * b_q;

            // Register operands; the skew keeps both valid bits aligned, so the
            // product is accumulated (wrapping) whenever they are set.
            always_ff @(posedge clk) begin
                if (clear) begin
                    a_q <= '0;
                    b_q <= '0;
                    a_v <= 1'b0;
                    b_v <= 1'b0;
                    acc <= '0;
                end else begin
                    {a_v, a_q} <= a_pipe[r][c];
                    {b_v, b_q} <= b_pipe[r][c];
                    if (a_v && b_v) acc <= acc + ACC_SIZE'(prod);
                end
            end

            if (c < COLS - 1) begin : g_right
                assign a_pipe[r][c+1] = {a_v, a_q};
            end
            if (r < ROWS - 1) begin : g_down
                assign b_pipe[r+1][c] = {b_v, b_q};
            end
            assign row_flat[r][(c+1)*ACC_SIZE-1 -: ACC_SIZE] = acc;
        end
    end
endmodule

// File: tb/tb_os_systolic_array.sv
// Directed bench for os_systolic_array: 4x4 grid with 32-bit accumulators plus
// 1x3 and 3x1 grids, checked against a 64-bit reference reduced modulo 2^32.
module tb_os_systolic_array;
    localparam int R  = 4;
    localparam int C  = 4;
    localparam int W  = 16;
    localparam int AW = 32;
    localparam int KW = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    os_systolic_array_if #(.ROWS(R), .COLS(C), .WORD_SIZE(W), .ACC_SIZE(AW), .K_W(KW)) m ();
    os_systolic_array #(.ROWS(R), .COLS(C), .WORD_SIZE(W), .ACC_SIZE(AW), .K_W(KW))
        u_dut (.clk(clk), .rst(rst), .io(m));

    os_systolic_array_if #(.ROWS(1), .COLS(3), .WORD_SIZE(W), .ACC_SIZE(AW), .K_W(KW)) n13 ();
    os_systolic_array #(.ROWS(1), .COLS(3), .WORD_SIZE(W), .ACC_SIZE(AW), .K_W(KW))
        u_13 (.clk(clk), .rst(rst), .io(n13));

    os_systolic_array_if #(.ROWS(3), .COLS(1), .WORD_SIZE(W), .ACC_SIZE(AW), .K_W(KW)) n31 ();
    os_systolic_array #(.ROWS(3), .COLS(1), .WORD_SIZE(W), .ACC_SIZE(AW), .K_W(KW))
        u_31 (.clk(clk), .rst(rst), .io(n31));

    int ga [4][32];
    int gb [32][4];
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [AW-1:0] exp_elem(input int r, input int c, input int k);
        longint s;
        s = 0;
        for (int kk = 0; kk < k; kk++) s += longint'(ga[r][kk]) * longint'(gb[kk][c]);
        return s[AW-1:0];
    endfunction

    function automatic logic [C*AW-1:0] exp_row(input int r, input int k);
        logic [C*AW-1:0] v;
        v = '1;
        if (r < R) for (int c = 0; c < C; c++) v[c*AW +: AW] = exp_elem(r, c, k);
        return v;
    endfunction

    function automatic int rnd16();
        return int'($urandom_range(65535)) - 32768;
    endfunction

    task automatic fill_random();
        for (int r = 0; r < 4; r++)
            for (int kk = 0; kk < 32; kk++) begin
                ga[r][kk] = rnd16();
                gb[kk][r] = rnd16();
            end
    endtask

    task automatic set_beat(input int idx, input int k);
        for (int r = 0; r < R; r++)
            m.left_in_bus[r*W +: W] = (idx < k) ? W'(ga[r][idx]) : W'($urandom);
        for (int c = 0; c < C; c++)
            m.top_in_bus[c*W +: W] = (idx < k) ? W'(gb[idx][c]) : W'($urandom);
    endtask

    // One job on the 4x4 engine: pv/pr are in_valid/out_ready percentages.
    task automatic run_job(input string name, input int k, input int pv, input int pr,
                           input bit timing, input bit poke);
        int beats, rows, first_ov;
        bit fin, stall, acc_now, hs;
        logic [C*AW-1:0] held;
        logic [1:0] held_row;
        @(posedge clk); #1;
        m.start = 1'b1;
        m.k_len = KW'(k);
        @(posedge clk); #1;
        m.start = 1'b0;
        check({name, " busy@T+1"}, m.busy, 1);
        check({name, " in_ready@T+1"}, m.in_ready, k > 0);
        beats = 0; rows = 0; first_ov = -1; fin = 0; stall = 0;
        held = '0; held_row = '0;
        for (int cyc = 0; cyc < 3000 && !fin; cyc++) begin
            if (m.done) begin
                fin = 1;
                check({name, " rows drained"}, rows, R);
                check({name, " beats consumed"}, beats, k);
                check({name, " busy with done"}, m.busy, 0);
                if (timing) begin
                    check({name, " first out_valid cycle"}, first_ov, k + R + C);
                    check({name, " done cycle"}, cyc, k + 2*R + C);
                end
            end else begin
                if (stall) begin
                    check({name, " hold valid"}, m.out_valid, 1);
                    check({name, " hold bus"}, m.out_bus, held);
                    check({name, " hold row"}, m.out_row, held_row);
                end
                if (m.out_valid) begin
                    if (first_ov < 0) first_ov = cyc;
                    check({name, " out_row"}, m.out_row, rows);
                    check({name, " out_bus"}, m.out_bus, exp_row(rows, k));
                    check({name, " out_last"}, m.out_last, rows == R - 1);
                end
                if (timing && cyc == k) check({name, " in_ready drop"}, m.in_ready, 0);
                m.in_valid  = ($urandom_range(99) < pv);
                set_beat(beats, k);
                acc_now     = m.in_valid && m.in_ready;
                m.out_ready = ($urandom_range(99) < pr);
                hs          = m.out_valid && m.out_ready;
                stall       = m.out_valid && !m.out_ready;
                held        = m.out_bus;
                held_row    = m.out_row;
                if (poke) begin
                    m.start = 1'($urandom_range(1));
                    m.k_len = KW'($urandom_range(255));
                end
                @(posedge clk); #1;
                beats += int'(acc_now);
                rows  += int'(hs);
            end
        end
        m.start = 1'b0; m.in_valid = 1'b0; m.out_ready = 1'b0;
        check({name, " done seen"}, fin, 1);
        @(posedge clk); #1;
        check({name, " done one cycle"}, m.done, 0);
        check({name, " idle after done"}, m.busy, 0);
    endtask

    // 1x3 and 3x1 grids run side by side with free-flowing handshakes.
    task automatic run_ns(input int k);
        int r13, r31;
        bit d13, d31;
        @(posedge clk); #1;
        n13.start = 1'b1; n13.k_len = KW'(k);
        n31.start = 1'b1; n31.k_len = KW'(k);
        @(posedge clk); #1;
        n13.start = 1'b0; n31.start = 1'b0;
        n13.in_valid = 1'b1; n31.in_valid = 1'b1;
        n13.out_ready = 1'b1; n31.out_ready = 1'b1;
        r13 = 0; r31 = 0; d13 = 0; d31 = 0;
        for (int cyc = 0; cyc < 200 && !(d13 && d31); cyc++) begin
            if (n13.done) d13 = 1;
            if (n31.done) d31 = 1;
            if (n13.out_valid) begin
                check("ns13 out_row", n13.out_row, r13);
                check("ns13 out_last", n13.out_last, 1);
                check("ns13 out_bus", n13.out_bus,
                      {exp_elem(0, 2, k), exp_elem(0, 1, k), exp_elem(0, 0, k)});
                r13++;
            end
            if (n31.out_valid) begin
                check("ns31 out_row", n31.out_row, r31);
                check("ns31 out_last", n31.out_last, r31 == 2);
                check("ns31 out_bus", n31.out_bus, (r31 < 3) ? exp_elem(r31, 0, k) : '1);
                r31++;
            end
            n13.left_in_bus = (cyc < k) ? W'(ga[0][cyc]) : '0;
            for (int c = 0; c < 3; c++)
                n13.top_in_bus[c*W +: W] = (cyc < k) ? W'(gb[cyc][c]) : '0;
            for (int r = 0; r < 3; r++)
                n31.left_in_bus[r*W +: W] = (cyc < k) ? W'(ga[r][cyc]) : '0;
            n31.top_in_bus = (cyc < k) ? W'(gb[cyc][0]) : '0;
            @(posedge clk); #1;
        end
        n13.in_valid = 1'b0; n31.in_valid = 1'b0;
        check("ns13 done seen", d13, 1);
        check("ns31 done seen", d31, 1);
        check("ns13 rows", r13, 1);
        check("ns31 rows", r31, 3);
    endtask

    initial begin
        m.start = 0; m.k_len = '0; m.in_valid = 0; m.left_in_bus = '0; m.top_in_bus = '0; m.out_ready = 0;
        n13.start = 0; n13.k_len = '0; n13.in_valid = 0; n13.left_in_bus = '0; n13.top_in_bus = '0; n13.out_ready = 0;
        n31.start = 0; n31.k_len = '0; n31.in_valid = 0; n31.left_in_bus = '0; n31.top_in_bus = '0; n31.out_ready = 0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("reset busy", m.busy, 0);
        check("reset in_ready", m.in_ready, 0);
        check("reset out_valid", m.out_valid, 0);
        check("reset out_bus", m.out_bus, 0);
        check("reset out_row", m.out_row, 0);
        check("reset out_last", m.out_last, 0);
        check("reset done", m.done, 0);

        for (int r = 0; r < 4; r++)
            for (int kk = 0; kk < 32; kk++) ga[r][kk] = (r == kk) ? 1 : 0;
        for (int kk = 0; kk < 32; kk++)
            for (int c = 0; c < 4; c++) gb[kk][c] = kk * 4 + c + 1;
        run_job("identity", 4, 100, 100, 1'b1, 1'b0);

        for (int r = 0; r < 4; r++)
            for (int kk = 0; kk < 32; kk++) begin
                ga[r][kk] = -32768;
                gb[kk][r] = -32768;
            end
        run_job("wrap_min", 3, 100, 100, 1'b0, 1'b0);

        for (int r = 0; r < 4; r++)
            for (int kk = 0; kk < 32; kk++) begin
                ga[r][kk] = -1;
                gb[kk][r] = -1;
            end
        run_job("neg_one", 3, 100, 100, 1'b0, 1'b0);

        fill_random();
        run_job("random_k17", 17, 50, 30, 1'b0, 1'b1);

        run_job("k_zero", 0, 60, 100, 1'b1, 1'b0);

        // Abandon a K=8 job after two beats, then run a clean K=2 job.
        fill_random();
        @(posedge clk); #1;
        m.start = 1'b1; m.k_len = KW'(8);
        @(posedge clk); #1;
        m.start = 1'b0; m.in_valid = 1'b1; set_beat(0, 8);
        @(posedge clk); #1;
        set_beat(1, 8);
        @(posedge clk); #1;
        set_beat(2, 8); rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; m.in_valid = 1'b0;
        check("mid_rst busy", m.busy, 0);
        check("mid_rst in_ready", m.in_ready, 0);
        check("mid_rst done", m.done, 0);
        fill_random();
        run_job("after_rst_k2", 2, 100, 100, 1'b0, 1'b0);

        fill_random();
        run_ns(5);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
